ibex_ibus_arbiter: RTL and testbench

IBEX_IBUS_ARBITER -- requirements
Module: ibex_ibus_arbiter

---
 rtl/ibex_ibus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ibex_ibus_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_ibus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ibex_ibus_arbiter
// Purpose  : Two-host instruction-bus arbiter. Host 0 (prefetch buffer) and
//            host 1 (secondary fetcher) share one instruction memory port.
//            The arbiter keeps an in-order FIFO of the host that owns each
//            outstanding transaction, so every response is routed back to
//            the host that issued it.
// Config   : IBEX_IBUS_ARB_RR_EN     - round-robin tie breaking
//                                      (default: fixed priority, host 0 wins)
//            IBEX_IBUS_ARB_ASSERT_ON - enables the protocol checkers
// Revision : 1.0 - initial release
// ============================================================================
module ibex_ibus_arbiter #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0]       host_req_i,
    input  logic [1:0][31:0] host_addr_i,
    output logic [1:0]       host_gnt_o,
    output logic [1:0]       host_rvalid_o,
    output logic [31:0]      host_rdata_o,
    output logic             host_err_o,
    output logic             instr_req_o,
    input  logic             instr_gnt_i,
    output logic [31:0]      instr_addr_o,
    input  logic             instr_rvalid_i,
    input  logic [31:0]      instr_rdata_i,
    input  logic             instr_err_i,
    output logic             busy_o
);

    localparam int unsigned c_PTR_W = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned c_CNT_W = $clog2(MaxOutstanding + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT  = c_CNT_W'(MaxOutstanding);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(MaxOutstanding - 1);

    // ST_HELD means a request was presented but not granted: the selected
    // host keeps the bus until the grant arrives.
    typedef enum logic [0:0] {
        ST_OPEN = 1'b0,
        ST_HELD = 1'b1
    } lock_state_e;

    lock_state_e                 r_lock_state;
    lock_state_e                 w_lock_state_next;
    logic                        r_held_sel;
    logic                        w_held_sel_next;

    logic                        w_arb_sel;
    logic                        w_sel;
    logic                        w_full;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_head;

    logic [c_CNT_W-1:0]          r_count;
    logic [c_PTR_W-1:0]          r_wptr;
    logic [c_PTR_W-1:0]          r_rptr;
    logic [MaxOutstanding-1:0]   r_id_fifo;

    // Word-aligned addresses: the byte-offset bits are intentionally dropped.
    logic                        w_unused_addr_lsb;
    assign w_unused_addr_lsb = ^{host_addr_i[1][1:0], host_addr_i[0][1:0]};

`ifdef IBEX_IBUS_ARB_RR_EN
    // Host that wins the next tie: always the one not granted last.
    logic r_prio;

    // Round-robin priority pointer, moved on every accepted request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prio <= 1'b0;
        end else if (w_push) begin
            r_prio <= ~w_sel;
        end
    end

    assign w_arb_sel = (&host_req_i) ? r_prio : (~host_req_i[0] & host_req_i[1]);
`else
    // Fixed priority: host 1 only wins when host 0 is idle.
    assign w_arb_sel = ~host_req_i[0] & host_req_i[1];
`endif

    // Request channel: a held selection overrides fresh arbitration.
    assign w_sel        = (r_lock_state == ST_HELD) ? r_held_sel : w_arb_sel;
    assign w_full       = (r_count == c_MAX_CNT);
    assign instr_req_o  = host_req_i[w_sel] & ~w_full;
    assign instr_addr_o = {host_addr_i[w_sel][31:2], 2'b00};
    assign w_push       = instr_req_o & instr_gnt_i;
    assign host_gnt_o   = w_push ? (w_sel ? 2'b10 : 2'b01) : 2'b00;

    // Response channel: responses with nothing outstanding are discarded.
    assign w_pop         = instr_rvalid_i & (r_count != '0);
    assign w_head        = r_id_fifo[r_rptr];
    assign host_rvalid_o = w_pop ? (w_head ? 2'b10 : 2'b01) : 2'b00;
    assign host_rdata_o  = instr_rdata_i;
    assign host_err_o    = instr_err_i;

    assign busy_o = (r_count != '0) | instr_req_o;

    // Lock next-state: hold the bus for a requester that is not yet granted.
    // A held host that drops its request yields ST_OPEN because instr_req_o
    // falls with it.
    always_comb begin
        w_lock_state_next = ST_OPEN;
        w_held_sel_next   = r_held_sel;
        if (instr_req_o && !instr_gnt_i) begin
            w_lock_state_next = ST_HELD;
            w_held_sel_next   = w_sel;
        end
    end

    // Lock state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock_state <= ST_OPEN;
            r_held_sel   <= 1'b0;
        end else begin
            r_lock_state <= w_lock_state_next;
            r_held_sel   <= w_held_sel_next;
        end
    end

    // Outstanding counter and FIFO pointers; pointers wrap at MaxOutstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == c_LAST_PTR) ? '0 : r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_LAST_PTR) ? '0 : r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ID FIFO storage; contents are only meaningful below r_count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_id_fifo[r_wptr] <= w_sel;
        end
    end

`ifdef IBEX_IBUS_ARB_ASSERT_ON
    // A held host must keep requesting until it is granted.
    a_held_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_lock_state == ST_HELD) |-> host_req_i[r_held_sel]);

    // A response must not arrive with nothing outstanding.
    a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_rvalid_i |-> (r_count != '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_ibex_ibus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_ibus_arbiter
// Purpose  : Self-checking bench for ibex_ibus_arbiter: directed scenarios
//            followed by constrained-random traffic against a transaction
//            level reference model (queue of owning hosts).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_ibus_arbiter;

    localparam int MAXO = 2;
`ifdef IBEX_IBUS_ARB_RR_EN
    localparam bit c_RR = 1'b1;
`else
    localparam bit c_RR = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [1:0]       host_req;
    logic [1:0][31:0] host_addr;
    logic [1:0]       host_gnt;
    logic [1:0]       host_rvalid;
    logic [31:0]      host_rdata;
    logic             host_err;
    logic             instr_req;
    logic             instr_gnt;
    logic [31:0]      instr_addr;
    logic             instr_rvalid;
    logic [31:0]      instr_rdata;
    logic             instr_err;
    logic             busy;

    int total = 0;
    int bad   = 0;

    // Reference model state: owners of outstanding transactions in order,
    // the host currently holding the bus (-1 = none) and the tie winner.
    int q[$];
    int held = -1;
    int prio = 0;

    ibex_ibus_arbiter #(.MaxOutstanding(MAXO)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .host_req_i     (host_req),
        .host_addr_i    (host_addr),
        .host_gnt_o     (host_gnt),
        .host_rvalid_o  (host_rvalid),
        .host_rdata_o   (host_rdata),
        .host_err_o     (host_err),
        .instr_req_o    (instr_req),
        .instr_gnt_i    (instr_gnt),
        .instr_addr_o   (instr_addr),
        .instr_rvalid_i (instr_rvalid),
        .instr_rdata_i  (instr_rdata),
        .instr_err_i    (instr_err),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive inputs after the falling edge, check all outputs
    // against the model, then advance the model to the post-edge state.
    task automatic step(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                        input logic gnt, input logic rv, input logic [31:0] rd, input logic er);
        int         sel;
        bit         full, e_req, e_busy, pop;
        logic [1:0] e_gnt, e_rv;
        logic [31:0] e_addr;
        @(negedge clk);
        host_req     = req;
        host_addr[0] = a0;
        host_addr[1] = a1;
        instr_gnt    = gnt;
        instr_rvalid = rv;
        instr_rdata  = rd;
        instr_err    = er;
        #1;
        full = (q.size() == MAXO);
        if (held >= 0)         sel = held;
        else if (req == 2'b11) sel = c_RR ? prio : 0;
        else                   sel = (req == 2'b10) ? 1 : 0;
        e_req  = req[sel] && !full;
        e_addr = ((sel == 1) ? a1 : a0) & 32'hFFFF_FFFC;
        e_gnt  = (e_req && gnt) ? 2'(1 << sel) : 2'b00;
        pop    = rv && (q.size() > 0);
        e_rv   = pop ? 2'(1 << q[0]) : 2'b00;
        e_busy = (q.size() != 0) || e_req;
        chk("req",    {31'd0, instr_req}, {31'd0, e_req});
        chk("addr",   instr_addr, e_addr);
        chk("gnt",    {30'd0, host_gnt}, {30'd0, e_gnt});
        chk("rvalid", {30'd0, host_rvalid}, {30'd0, e_rv});
        chk("rdata",  host_rdata, rd);
        chk("err",    {31'd0, host_err}, {31'd0, er});
        chk("busy",   {31'd0, busy}, {31'd0, e_busy});
        if (pop) void'(q.pop_front());
        if (e_req && gnt) begin
            q.push_back(sel);
            prio = 1 - sel;
        end
        held = (e_req && !gnt) ? sel : -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        host_req     = 2'b00;
        host_addr    = '0;
        instr_gnt    = 1'b0;
        instr_rvalid = 1'b0;
        instr_rdata  = 32'd0;
        instr_err    = 1'b0;
        #1;
        chk("rst_gnt",    {30'd0, host_gnt}, 32'd0);
        chk("rst_rvalid", {30'd0, host_rvalid}, 32'd0);
        chk("rst_req",    {31'd0, instr_req}, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        held = -1;
        prio = 0;
    endtask

    initial begin
        logic [1:0]  r;
        logic [31:0] ra0, ra1;
        rst_n = 1'b1;
        do_reset();

        // Single host round trip.
        step(2'b01, 32'h80, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t030_gnt", {30'd0, host_gnt}, 32'h1);
        chk("t030_addr", instr_addr, 32'h80);
        step(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        chk("t030_rv", {30'd0, host_rvalid}, 32'h1);
        chk("t030_rdata", host_rdata, 32'hDEADBEEF);
        step(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t030_busy", {31'd0, busy}, 32'd0);

        // Lock: host 0 held without grant while host 1 joins.
        do_reset();
        step(2'b01, 32'h100, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t031_addr0", instr_addr, 32'h100);
        step(2'b11, 32'h100, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t031_addr1", instr_addr, 32'h100);
        step(2'b11, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t031_gnt0", {30'd0, host_gnt}, 32'h1);
        step(2'b10, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t031_gnt1", {30'd0, host_gnt}, 32'h2);
        chk("t031_addr3", instr_addr, 32'h200);
        step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1111, 1'b0);
        step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h2222, 1'b0);

        // Full: no bypass from the freeing response.
        do_reset();
        step(2'b01, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(2'b01, 32'h14, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(2'b01, 32'h18, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t032_full_req", {31'd0, instr_req}, 32'd0);
        step(2'b01, 32'h18, 32'h0, 1'b0, 1'b1, 32'h5, 1'b0);
        chk("t032_nobypass", {31'd0, instr_req}, 32'd0);
        step(2'b01, 32'h18, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t032_reassert", {31'd0, instr_req}, 32'd1);
        step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h6, 1'b0);
        step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h7, 1'b0);

        // Ordering and error broadcast.
        do_reset();
        step(2'b10, 32'h0, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0);
        step(2'b01, 32'h44, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hA, 1'b0);
        chk("t033_rv1", {30'd0, host_rvalid}, 32'h2);
        step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hB, 1'b1);
        chk("t033_rv0", {30'd0, host_rvalid}, 32'h1);
        chk("t033_err", {31'd0, host_err}, 32'd1);

        // Arbitration under continuous contention.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 32'h300, 32'h400, 1'b1, (i != 0), 32'h0, 1'b0);
`ifdef IBEX_IBUS_ARB_RR_EN
            chk("t034_rr", {30'd0, host_gnt}, (i % 2 == 0) ? 32'h1 : 32'h2);
`else
            chk("t034_fixed", {30'd0, host_gnt}, 32'h1);
`endif
        end
        step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);

        // Reset with two outstanding, then a stray response.
        do_reset();
        step(2'b01, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(2'b10, 32'h0, 32'h24, 1'b1, 1'b0, 32'h0, 1'b0);
        do_reset();
        step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hBAD, 1'b0);
        chk("t035_rv", {30'd0, host_rvalid}, 32'd0);
        step(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t035_busy", {31'd0, busy}, 32'd0);

        // Random legal traffic: a held host keeps its request and address.
        do_reset();
        ra0 = 32'h0;
        ra1 = 32'h0;
        for (int i = 0; i < 400; i++) begin
            r = 2'($urandom);
            if (held >= 0) r[held] = 1'b1;
            if (held != 0) ra0 = $urandom;
            if (held != 1) ra1 = $urandom;
            step(r, ra0, ra1, 1'($urandom), (q.size() > 0) && ($urandom_range(2) != 0),
                 $urandom, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
